// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that shares one external bit-serial adder between two
// parallel requesters and reassembles the LSB-first sum into a W-bit result.
module serial_add_scheduler #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic [1:0]     req_ready,
  output logic           ser_rst,
  output logic           ser_vld,
  output logic           ser_a,
  output logic           ser_b,
  output logic           ser_last,
  input  logic           ser_sum,
  output logic           res_valid,
  output logic [W-1:0]   res_sum,
  output logic           res_id,
  input  logic           res_ready
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic          prio;
  logic [CW-1:0] cnt;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          grant;
  logic          handshake;

  // The pointer requester wins a tie; otherwise whichever one is valid.
  assign grant     = req_valid[prio] ? prio : ~prio;
  assign req_ready = (rst_n && state == IDLE && |req_valid)
                     ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign handshake = |req_ready;

  // Serial outputs are forced low while reset is asserted so an aborted
  // operation never leaks a bit pair into the adder.
  assign ser_rst   = ~rst_n;
  assign ser_vld   = rst_n && state == SHIFT;
  assign ser_a     = ser_vld && op_a[cnt];
  assign ser_b     = ser_vld && op_b[cnt];
  assign ser_last  = ser_vld && cnt == CNT_MAX;
  assign res_valid = rst_n && state == DONE;

  // NOTE: reset is synchronous (sampled on the clock edge), and all state
  // uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= 1'b0;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_sum <= '0;
      res_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            op_a   <= grant ? req_a[W +: W] : req_a[0 +: W];
            op_b   <= grant ? req_b[W +: W] : req_b[0 +: W];
            res_id <= grant;
            prio   <= ~grant;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_sum[cnt] <= ser_sum;
          cnt          <= cnt + 1'b1;
          if (cnt == CNT_MAX) state <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Randomized self-checking bench: a behavioural serial adder closes the loop
// and expected results come from plain arithmetic and a round-robin pointer.
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_ready;
  logic           ser_rst;
  logic           ser_vld;
  logic           ser_a;
  logic           ser_b;
  logic           ser_last;
  logic           ser_sum;
  logic           res_valid;
  logic [W-1:0]   res_sum;
  logic           res_id;
  logic           res_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit prio_m  = 1'b0;

  serial_add_scheduler #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .ser_rst(ser_rst), .ser_vld(ser_vld), .ser_a(ser_a),
    .ser_b(ser_b), .ser_last(ser_last), .ser_sum(ser_sum), .res_valid(res_valid),
    .res_sum(res_sum), .res_id(res_id), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // External bit-serial adder: carry register cleared by ser_rst or after last.
  logic carry;
  assign ser_sum = ser_a ^ ser_b ^ carry;
  always @(posedge clk) begin
    if (ser_rst) carry <= 1'b0;
    else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry & (ser_a ^ ser_b)));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation starting from IDLE; all driving and sampling at negedge.
  task automatic run_op(input logic [1:0] vmask, input logic [W-1:0] a0, b0, a1, b1,
                        input int stall, input bit keep, input bit change);
    bit           g;
    logic [W-1:0] ea, eb, exp_sum;
    int           n;
    req_valid = vmask;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    g         = vmask[prio_m] ? prio_m : ~prio_m;
    ea        = g ? a1 : a0;
    eb        = g ? b1 : b0;
    exp_sum   = W'((int'(ea) + int'(eb)) % (1 << W));
    #1;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 32'(req_ready), g ? 32'h2 : 32'h1);
    prio_m = ~g;
    @(negedge clk);
    if (!keep) req_valid = 2'b00;
    if (change) begin
      req_a = ~req_a;
      req_b = req_b ^ {2*W{1'b1}};
    end
    for (int i = 1; i <= W; i++) begin
      check("ser_vld", 32'(ser_vld), 32'h1);
      check("ser_last", 32'(ser_last), 32'(i == W));
      check("ser_ab", {30'h0, ser_a, ser_b}, {30'h0, ea[i-1], eb[i-1]});
      check("ready_shift", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    check("vld_after", 32'(ser_vld), 32'h0);
    check("res_valid", 32'(res_valid), 32'h1);
    check("res_sum", 32'(res_sum), 32'(exp_sum));
    check("res_id", 32'(res_id), 32'(g));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'h1);
      check("hold_sum", 32'(res_sum), 32'(exp_sum));
      check("hold_id", 32'(res_id), 32'(g));
      check("hold_ready", 32'(req_ready), 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_drop", 32'(res_valid), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ser_rst", 32'(ser_rst), 32'h1);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_vld", 32'(ser_vld), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_sum", 32'(res_sum), 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);
    check("ser_rst_off", 32'(ser_rst), 32'h0);

    run_op(2'b01, 8'h35, 8'h4C, 8'h00, 8'h00, 0, 1'b0, 1'b0);   // 0x81
    run_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 1'b0, 1'b0);   // wrap to 0x00
    run_op(2'b10, 8'h00, 8'h00, 8'h01, 8'h01, 0, 1'b0, 1'b0);   // carry cleared
    for (int k = 0; k < 4; k++)
      run_op(2'b11, 8'h10, 8'h01, 8'h20, 8'h02, 0, 1'b1, 1'b0);
    run_op(2'b01, 8'h5A, 8'h33, 8'h00, 8'h00, 5, 1'b0, 1'b0);   // backpressure
    run_op(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 0, 1'b0, 1'b1);   // operand change

    // Abort an operation at cnt == 3 with a one-cycle reset.
    req_valid = 2'b01;
    req_a     = {8'h00, 8'hAA};
    req_b     = {8'h00, 8'h77};
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("pre_rst_vld", 32'(ser_vld), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_ser_rst", 32'(ser_rst), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_vld", 32'(ser_vld), 32'h0);
    prio_m = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      check("abort_no_res", {30'h0, res_valid, ser_vld}, 32'h0);
      @(negedge clk);
    end
    run_op(2'b01, 8'h0F, 8'h01, 8'h00, 8'h00, 0, 1'b0, 1'b0);   // 0x10

    for (int r = 0; r < 16; r++)
      run_op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
